// File: rtl/dot_product_rr_arbiter.sv
// Round-robin, packet-granular arbiter sharing one dot-product engine; a tag FIFO steers results back.
// Optional macro DP_ARB_STATS_EN adds per-requester saturating packet counters on pkt_count.
module dot_product_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int LANES     = 8,
    parameter int DW        = 8,
    parameter int ACC_W     = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*LANES*DW-1:0] req_t_data,
    input  logic [NUM_REQ*LANES*DW-1:0] req_weights,
    output logic                        eng_in_valid,
    output logic                        eng_in_last,
    input  logic                        eng_in_ready,
    output logic [LANES*DW-1:0]         eng_t_data,
    output logic [LANES*DW-1:0]         eng_weights,
    input  logic                        eng_out_valid,
    input  logic [ACC_W-1:0]            eng_dot_product,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [ACC_W-1:0]            rsp_data,
    output logic                        busy,
    output logic                        err_orphan
`ifdef DP_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]       pkt_count
`endif
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam int VW = LANES * DW;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]        tag_mem_q [TAG_DEPTH];
    logic [OW-1:0]        tag_mem_d [TAG_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [ACC_W-1:0]     rsp_data_q, rsp_data_d;
    logic                 err_orphan_q, err_orphan_d;

    logic                 pick_found;
    logic [OW-1:0]        pick_idx;
    logic [OW-1:0]        cand;
    logic                 push;
    logic                 pop;

    // First valid requester strictly after the last winner, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = OW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        eng_in_valid = 1'b0;
        eng_in_last  = 1'b0;
        eng_t_data   = '0;
        eng_weights  = '0;
        req_ready    = '0;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && (count_q < CW'(TAG_DEPTH))) begin
                    owner_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                eng_in_valid       = req_valid[owner_q];
                eng_in_last        = req_last[owner_q];
                eng_t_data         = req_t_data[int'(owner_q)*VW +: VW];
                eng_weights        = req_weights[int'(owner_q)*VW +: VW];
                req_ready[owner_q] = eng_in_ready;
                if (eng_in_valid && eng_in_ready && eng_in_last) begin
                    push     = 1'b1;
                    rr_ptr_d = owner_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag FIFO; a result with nothing in flight is flagged as an orphan instead of popping.
    always_comb begin
        pop          = eng_out_valid && (count_q != '0);
        tag_mem_d    = tag_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        err_orphan_d = err_orphan_q | (eng_out_valid && (count_q == '0));
        if (push) begin
            tag_mem_d[wr_ptr_q] = owner_q;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d                       = rd_ptr_q + 1'b1;
            rsp_valid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
            rsp_data_d                     = eng_dot_product;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= OW'(NUM_REQ - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            err_orphan_q <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            err_orphan_q <= err_orphan_d;
            tag_mem_q    <= tag_mem_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign err_orphan = err_orphan_q;
    assign busy       = (state_q == GRANT) || (count_q != '0);

`ifdef DP_ARB_STATS_EN
    logic [15:0] pkt_cnt_q [NUM_REQ];
    logic [15:0] pkt_cnt_d [NUM_REQ];

    always_comb begin
        pkt_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pkt_cnt_d[i] = pkt_cnt_q[i];
            if (rsp_valid_q[i] && (pkt_cnt_q[i] != 16'hFFFF)) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + 16'd1;
            end
            pkt_count[i*16 +: 16] = pkt_cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_dot_product_rr_arbiter.sv
// Randomized bench for dot_product_rr_arbiter against a queue-based model of grants and in-flight tags.
module tb_dot_product_rr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int LANES     = 8;
    localparam int DW        = 8;
    localparam int ACC_W     = 32;
    localparam int TAG_DEPTH = 4;
    localparam int VW        = LANES * DW;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*VW-1:0]  req_t_data;
    logic [NUM_REQ*VW-1:0]  req_weights;
    logic                   eng_in_valid;
    logic                   eng_in_last;
    logic                   eng_in_ready;
    logic [VW-1:0]          eng_t_data;
    logic [VW-1:0]          eng_weights;
    logic                   eng_out_valid;
    logic [ACC_W-1:0]       eng_dot_product;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [ACC_W-1:0]       rsp_data;
    logic                   busy;
    logic                   err_orphan;
`ifdef DP_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]  pkt_count;
`endif

    dot_product_rr_arbiter #(
        .NUM_REQ(NUM_REQ), .LANES(LANES), .DW(DW), .ACC_W(ACC_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
        .req_t_data(req_t_data), .req_weights(req_weights),
        .eng_in_valid(eng_in_valid), .eng_in_last(eng_in_last), .eng_in_ready(eng_in_ready),
        .eng_t_data(eng_t_data), .eng_weights(eng_weights),
        .eng_out_valid(eng_out_valid), .eng_dot_product(eng_dot_product),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err_orphan(err_orphan)
`ifdef DP_ARB_STATS_EN
        , .pkt_count(pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit                 m_granted;
    int                 m_owner;
    int                 m_last;
    int                 m_tagq[$];
    logic [NUM_REQ-1:0] m_rsp_valid;
    logic [ACC_W-1:0]   m_rsp_data;
    bit                 m_err;
    int                 m_pkt[NUM_REQ];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_granted   = 1'b0;
        m_owner     = 0;
        m_last      = NUM_REQ - 1;
        m_tagq.delete();
        m_rsp_valid = '0;
        m_rsp_data  = '0;
        m_err       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) m_pkt[i] = 0;
    endtask

    task automatic compare_outputs();
        logic               e_valid;
        logic               e_last;
        logic [NUM_REQ-1:0] e_ready;
        logic [VW-1:0]      e_data;
        logic [VW-1:0]      e_w;
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_ready = '0;
        e_data  = '0;
        e_w     = '0;
        if (m_granted) begin
            e_valid = req_valid[m_owner];
            e_last  = req_last[m_owner];
            e_data  = req_t_data[m_owner*VW +: VW];
            e_w     = req_weights[m_owner*VW +: VW];
            e_ready[m_owner] = eng_in_ready;
        end
        checkOutput("eng_in_valid", 64'(eng_in_valid), 64'(e_valid));
        checkOutput("eng_in_last", 64'(eng_in_last), 64'(e_last));
        checkOutput("req_ready", 64'(req_ready), 64'(e_ready));
        checkOutput("eng_t_data", 64'(eng_t_data), 64'(e_data));
        checkOutput("eng_weights", 64'(eng_weights), 64'(e_w));
        checkOutput("busy", 64'(busy), 64'(m_granted || (m_tagq.size() > 0)));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        checkOutput("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
        checkOutput("err_orphan", 64'(err_orphan), 64'(m_err));
`ifdef DP_ARB_STATS_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            checkOutput("pkt_count", 64'(pkt_count[i*16 +: 16]), 64'(m_pkt[i]));
        end
`endif
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_step();
        int  size0;
        int  h;
        int  c;
        bit  acc_last;
        size0    = m_tagq.size();
        acc_last = m_granted && req_valid[m_owner] && eng_in_ready && req_last[m_owner];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_rsp_valid[i] && (m_pkt[i] < 65535)) m_pkt[i]++;
        end
        m_rsp_valid = '0;
        if (eng_out_valid) begin
            if (size0 > 0) begin
                h = m_tagq.pop_front();
                m_rsp_valid[h] = 1'b1;
                m_rsp_data     = eng_dot_product;
            end else begin
                m_err = 1'b1;
            end
        end
        if (acc_last) begin
            m_tagq.push_back(m_owner);
            m_last    = m_owner;
            m_granted = 1'b0;
        end else if (!m_granted && (size0 < TAG_DEPTH)) begin
            for (int j = 1; j <= NUM_REQ; j++) begin
                c = (m_last + j) % NUM_REQ;
                if (!m_granted && req_valid[c]) begin
                    m_granted = 1'b1;
                    m_owner   = c;
                end
            end
        end
    endtask

    task automatic drive_cycle(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] l,
                               input logic rdy, input logic ov, input logic [ACC_W-1:0] dp);
        @(negedge clk);
        req_valid       = v;
        req_last        = l;
        eng_in_ready    = rdy;
        eng_out_valid   = ov;
        eng_dot_product = dp;
        for (int k = 0; k < NUM_REQ*VW/32; k++) begin
            req_t_data[k*32 +: 32]  = $urandom;
            req_weights[k*32 +: 32] = $urandom;
        end
        #1;
        compare_outputs();
        model_step();
    endtask

    task automatic applyStimulus(input int cycles, input logic [NUM_REQ-1:0] mask, input int p_valid,
                                 input int p_last, input int p_ready, input int p_out);
        logic [NUM_REQ-1:0] v;
        logic [NUM_REQ-1:0] l;
        for (int c = 0; c < cycles; c++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                v[r] = mask[r] && (int'($urandom_range(99)) < p_valid);
                l[r] = int'($urandom_range(99)) < p_last;
            end
            drive_cycle(v, l, int'($urandom_range(99)) < p_ready,
                        int'($urandom_range(99)) < p_out, $urandom);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst           = 1'b1;
        req_valid     = $urandom;
        eng_out_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst           = 1'b0;
        req_valid     = '0;
        req_last      = '0;
        eng_out_valid = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        model_step();
    endtask

    initial begin
        rst             = 1'b1;
        req_valid       = '0;
        req_last        = '0;
        req_t_data      = '0;
        req_weights     = '0;
        eng_in_ready    = 1'b0;
        eng_out_valid   = 1'b0;
        eng_dot_product = '0;
        model_reset();
        applyReset();

        // Requester 2 alone: arbitration cycle, three beats, then its result.
        drive_cycle(4'b0100, 4'b0000, 1'b1, 1'b0, 32'h0);
        drive_cycle(4'b0100, 4'b0000, 1'b1, 1'b0, 32'h0);
        drive_cycle(4'b0100, 4'b0000, 1'b1, 1'b0, 32'h0);
        drive_cycle(4'b0100, 4'b0100, 1'b1, 1'b0, 32'h0);
        drive_cycle(4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0000_1234);
        drive_cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0);
        checkOutput("dir_rsp_valid", 64'(rsp_valid), 64'h4);
        checkOutput("dir_rsp_data", 64'(rsp_data), 64'h1234);

        // Orphan result with nothing in flight, sticky until reset.
        drive_cycle(4'b0000, 4'b0000, 1'b1, 1'b1, 32'hDEAD_BEEF);
        drive_cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0);
        checkOutput("dir_orphan", 64'(err_orphan), 64'h1);
        applyStimulus(10, 4'b0000, 0, 0, 100, 0);
        applyReset();

        // Everyone valid with single-beat packets, then backpressure, then a full tag FIFO.
        applyStimulus(30, 4'b1111, 100, 100, 100, 0);
        applyStimulus(6, 4'b0000, 0, 0, 100, 100);
        applyStimulus(60, 4'b1111, 90, 30, 30, 15);
        applyStimulus(30, 4'b1111, 100, 100, 100, 0);
        drive_cycle(4'b1111, 4'b1111, 1'b1, 1'b1, $urandom);
        applyStimulus(20, 4'b1111, 100, 100, 100, 50);

        // Reset in the middle of a 4-beat packet from requester 0.
        applyReset();
        drive_cycle(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0);
        drive_cycle(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0);
        drive_cycle(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0);
        applyReset();
        drive_cycle(4'b1001, 4'b1001, 1'b1, 1'b0, 32'h0);
        drive_cycle(4'b1001, 4'b1001, 1'b1, 1'b0, 32'h0);
        checkOutput("dir_rst_grant0", 64'(req_ready), 64'h1);

        for (int blk = 0; blk < 8; blk++) begin
            applyStimulus(150, 4'b1111, 70, 35, 75, 25);
            if (blk == 3) applyReset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
